// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: byte-side bundle of the 8N1 receiver.
// data_out/data_valid feed the packer; frame_err/rx_busy report status.
interface uart_byte_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output rx_busy
  );

  modport slave (
    input data_out,
    input data_valid,
    input frame_err,
    input rx_busy
  );
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 LSB-first serial receiver, one byte + 1-cycle strobe.
// Ports: clk, rst (sync, high), rx (async line), out (byte/status bundle).
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_byte_rx_if.master out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          rx_m;
  logic          rx_s;
  logic [1:0]    settle;
  logic          synced;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [2:0]    idx;
  logic [2:0]    idx_nx;
  logic [7:0]    shreg;
  logic [7:0]    shreg_nx;
  logic [7:0]    dout;
  logic [7:0]    dout_nx;
  logic          dv;
  logic          dv_nx;
  logic          fe;
  logic          fe_nx;

  // The sync flops reset high, so for two cycles after reset rx_s
  // is not the real line. settle gates WAIT_IDLE until it is, so a
  // line held low across reset is never taken for idle.
  assign synced = (settle == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      settle <= 2'd0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (!synced) begin
        settle <= settle + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shreg <= 8'h00;
      dout  <= 8'h00;
      dv    <= 1'b0;
      fe    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
      dout  <= dout_nx;
      dv    <= dv_nx;
      fe    <= fe_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + {{(CW-1){1'b0}}, 1'b1};
    idx_nx   = idx;
    shreg_nx = shreg;
    dout_nx  = dout;
    dv_nx    = 1'b0;
    fe_nx    = 1'b0;
    unique case (state)
      WAIT_IDLE: begin
        cnt_nx = '0;
        if (synced && rx_s) begin
          state_nx = IDLE;
        end
      end
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) begin
          state_nx = START;
        end
      end
      START: begin
        // Mid start bit: still low means a real frame.
        if (cnt == HALF_LAST) begin
          cnt_nx   = '0;
          idx_nx   = 3'd0;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s, shreg[7:1]};
          idx_nx   = idx + 3'd1;
          if (idx == 3'd7) begin
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            dout_nx  = shreg;
            dv_nx    = 1'b1;
            state_nx = IDLE;
          end else begin
            // Line may still be low (break); wait for idle.
            fe_nx    = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end
      end
      default: begin
        state_nx = WAIT_IDLE;
      end
    endcase
  end

  assign out.data_out   = dout;
  assign out.data_valid = dv;
  assign out.frame_err  = fe;
  assign out.rx_busy    = (state == START) ||
                          (state == DATA)  ||
                          (state == STOP);

endmodule
